// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle processor controller: FSM states,
// instruction fields, ALU operation classes and the per-state control bundle.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  // Raw per-state controls, before reset gating and PCEn formation.
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    alu_op_t    alu_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU decoder: maps the ALU operation class and funct field to
// an ALUControl code, and flags whether funct is a supported R-type function.
module alu_decoder
  import multicycle_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_valid
);

  logic [2:0] funct_ctl;

  // funct_valid ignores alu_op so DECODE can screen R-type functs early.
  always_comb begin
    funct_valid = 1'b1;
    funct_ctl   = ALUC_ADD;
    case (funct)
      FN_ADD:  funct_ctl = ALUC_ADD;
      FN_SUB:  funct_ctl = ALUC_SUB;
      FN_AND:  funct_ctl = ALUC_AND;
      FN_OR:   funct_ctl = ALUC_OR;
      FN_SLT:  funct_ctl = ALUC_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    alu_control = ALUC_ADD;
    case (alu_op)
      ALUOP_ADD:   alu_control = ALUC_ADD;
      ALUOP_SUB:   alu_control = ALUC_SUB;
      ALUOP_FUNCT: alu_control = funct_ctl;
      default:     alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing fetch/decode/execute/memory/writeback for the
// multicycle processor and decoding every datapath enable from the state.
module multicycle_control_unit
  import multicycle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCEn,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       illegal_instr
);

  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic   funct_valid;
  logic   decode_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign decode_bad = !op_supported(op) || ((op == OP_RTYPE) && !funct_valid);

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_valid ? S_EXECUTE : S_FETCH;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = 2'b01;
      end
      S_DECODE:   ctrl.alu_src_b = 2'b11;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_MEMRD:    ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
        ctrl.pc_src    = 2'b01;
      end
      S_ADDIEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_ADDIWB:   ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = 2'b10;
      end
      default:    ctrl = '0;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (ctrl.alu_op),
    .funct       (funct),
    .alu_control (ALUControl),
    .funct_valid (funct_valid)
  );

  // Write strobes are masked while reset is held so an abandoned instruction
  // cannot touch the PC, IR, register file or memory.
  assign IRWrite       = ctrl.ir_write & ~reset;
  assign PCEn          = (ctrl.pc_write | (ctrl.branch & zero)) & ~reset;
  assign MemWrite      = ctrl.mem_write & ~reset;
  assign RegWrite      = ctrl.reg_write & ~reset;
  assign illegal_instr = (state_q == S_DECODE) & decode_bad & ~reset;

  assign IorD     = ctrl.iord;
  assign RegDst   = ctrl.reg_dst;
  assign MemtoReg = ctrl.mem_to_reg;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign PCSrc    = ctrl.pc_src;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class
// cycle by cycle and compares the packed output vector with hand values.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       IorD, MemWrite, IRWrite, PCEn, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       illegal_instr;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_control_unit dut (
    .clk           (clk),
    .reset         (reset),
    .op            (op),
    .funct         (funct),
    .zero          (zero),
    .IorD          (IorD),
    .MemWrite      (MemWrite),
    .IRWrite       (IRWrite),
    .PCEn          (PCEn),
    .RegDst        (RegDst),
    .MemtoReg      (MemtoReg),
    .RegWrite      (RegWrite),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .PCSrc         (PCSrc),
    .ALUControl    (ALUControl),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  // {IorD,MemWrite,IRWrite,PCEn,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSrc,ALUControl,illegal_instr}
  logic [15:0] outs;
  assign outs = {IorD, MemWrite, IRWrite, PCEn, RegDst, MemtoReg, RegWrite, ALUSrcA,
                 ALUSrcB, PCSrc, ALUControl, illegal_instr};

  localparam logic [15:0] V_RESET   = {8'b0000_0000, 2'b01, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] V_FETCH   = {8'b0011_0000, 2'b01, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] V_DECODE  = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] V_DEC_ILL = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b1};
  localparam logic [15:0] V_MEMADR  = {8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] V_MEMRD   = {8'b1000_0000, 2'b00, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] V_MEMWB   = {8'b0000_0110, 2'b00, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] V_MEMWR   = {8'b1100_0000, 2'b00, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] V_ALUWB   = {8'b0000_1010, 2'b00, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] V_BR_Z1   = {8'b0001_0001, 2'b00, 2'b01, 3'b110, 1'b0};
  localparam logic [15:0] V_BR_Z0   = {8'b0000_0001, 2'b00, 2'b01, 3'b110, 1'b0};
  localparam logic [15:0] V_ADDIEX  = {8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] V_ADDIWB  = {8'b0000_0010, 2'b00, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] V_JUMP    = {8'b0001_0000, 2'b00, 2'b10, 3'b010, 1'b0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Check the current cycle's outputs, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [15:0] exp);
    check_eq(tag, {16'h0, outs}, {16'h0, exp});
    @(posedge clk);
    #1;
  endtask

  logic [5:0] fn_tab  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] alu_tab [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

  initial begin
    reset = 1'b1;
    op    = 6'b100011;
    funct = 6'b000000;
    zero  = 1'b0;
    #3;
    check_eq("reset_gated", {16'h0, outs}, {16'h0, V_RESET});
    @(negedge clk);
    reset = 1'b0;
    #1;

    // lw: IorD in the writeback cycle is masked out of that comparison
    cyc("lw_c1_fetch", V_FETCH);
    cyc("lw_c2_decode", V_DECODE);
    cyc("lw_c3_memadr", V_MEMADR);
    cyc("lw_c4_memrd", V_MEMRD);
    check_eq("lw_c5_memwb", {17'h0, outs[14:0]}, {17'h0, V_MEMWB[14:0]});
    @(posedge clk);
    #1;
    $display("[%0t] lw complete", $time);

    // R-type, one pass per supported funct
    for (int i = 0; i < 5; i++) begin
      op    = 6'b000000;
      funct = fn_tab[i];
      cyc($sformatf("r%0d_c1_fetch", i), V_FETCH);
      cyc($sformatf("r%0d_c2_decode", i), V_DECODE);
      cyc($sformatf("r%0d_c3_exec", i), {8'b0000_0001, 2'b00, 2'b00, alu_tab[i], 1'b0});
      cyc($sformatf("r%0d_c4_aluwb", i), V_ALUWB);
      $display("[%0t] rtype funct=%b complete", $time, fn_tab[i]);
    end

    // beq taken, with zero toggled inside BRANCH to show PCEn is combinational
    op = 6'b000100;
    funct = 6'b000000;
    cyc("beq1_c1_fetch", V_FETCH);
    zero = 1'b1;
    cyc("beq1_c2_decode", V_DECODE);
    check_eq("beq1_c3_z1", {16'h0, outs}, {16'h0, V_BR_Z1});
    zero = 1'b0;
    #1;
    check_eq("beq1_c3_zdrop", {31'h0, PCEn}, 32'h0);
    zero = 1'b1;
    #1;
    cyc("beq1_c3_zback", V_BR_Z1);
    zero = 1'b0;
    $display("[%0t] beq taken complete", $time);

    cyc("beq0_c1_fetch", V_FETCH);
    cyc("beq0_c2_decode", V_DECODE);
    cyc("beq0_c3_branch", V_BR_Z0);
    $display("[%0t] beq not-taken complete", $time);

    op = 6'b001000;
    cyc("addi_c1_fetch", V_FETCH);
    cyc("addi_c2_decode", V_DECODE);
    cyc("addi_c3_exec", V_ADDIEX);
    cyc("addi_c4_wb", V_ADDIWB);
    $display("[%0t] addi complete", $time);

    op = 6'b000010;
    cyc("j_c1_fetch", V_FETCH);
    cyc("j_c2_decode", V_DECODE);
    cyc("j_c3_jump", V_JUMP);
    $display("[%0t] j complete", $time);

    op = 6'b111111;
    cyc("illop_c1_fetch", V_FETCH);
    cyc("illop_c2_decode", V_DEC_ILL);
    $display("[%0t] illegal op complete", $time);

    op = 6'b000000;
    funct = 6'b000111;
    cyc("illfn_c1_fetch", V_FETCH);
    cyc("illfn_c2_decode", V_DEC_ILL);
    $display("[%0t] illegal funct complete", $time);

    // sw, then reset mid-cycle while in MEMWR
    op = 6'b101011;
    funct = 6'b000000;
    cyc("sw_c1_fetch", V_FETCH);
    cyc("sw_c2_decode", V_DECODE);
    cyc("sw_c3_memadr", V_MEMADR);
    check_eq("sw_c4_memwr", {16'h0, outs}, {16'h0, V_MEMWR});
    #2;
    reset = 1'b1;
    #1;
    check_eq("sw_rst_async", {16'h0, outs}, {16'h0, V_RESET});
    @(posedge clk);
    #1;
    check_eq("sw_rst_held", {16'h0, outs}, {16'h0, V_RESET});
    @(negedge clk);
    reset = 1'b0;
    #1;
    $display("[%0t] sw aborted by reset", $time);

    op = 6'b100011;
    cyc("post_c1_fetch", V_FETCH);
    cyc("post_c2_decode", V_DECODE);
    cyc("post_c3_memadr", V_MEMADR);
    $display("[%0t] resume after reset complete", $time);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
